// File: rtl/wb_bus_master.sv
// Wishbone-style bus master: turns one CPU load/store request into a strobed slave
// access. An ACK, a timeout or an address that decodes to no slave ends the access.
module wb_bus_master #(
    parameter int N_SLAVES = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ack,
    output logic                    cpu_err,
    output logic                    cpu_busy,
    output logic [N_SLAVES-1:0]     STB,
    output logic                    WE,
    output logic [31:0]             DAT_O,
    input  logic [32*N_SLAVES-1:0]  DAT_I,
    input  logic [N_SLAVES-1:0]     ACK
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          idx, idx_nxt;
    logic [TW-1:0]       timer, timer_nxt;
    logic [N_SLAVES-1:0] stb_nxt;
    logic                we_nxt;
    logic [31:0]         dat_o_nxt;
    logic [31:0]         rdata_nxt;
    logic                ack_nxt;
    logic                err_nxt;
    logic                busy_nxt;

    logic [3:0]          req_idx;
    logic                req_valid;
    logic [N_SLAVES-1:0] req_onehot;
    logic                sel_ack;
    logic [31:0]         sel_dat;
    logic                unused_addr_bits;

    assign req_idx          = cpu_addr[31:28];
    assign req_valid        = int'(req_idx) < N_SLAVES;
    assign unused_addr_bits = ^cpu_addr[27:0];

    // Only the selected slave's ACK and data are looked at; other ACK bits are ignored.
    always_comb begin
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_dat    = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (req_idx == 4'(k)) req_onehot[k] = 1'b1;
            if (idx == 4'(k)) begin
                sel_ack = ACK[k];
                sel_dat = DAT_I[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer;
        stb_nxt   = STB;
        we_nxt    = WE;
        dat_o_nxt = DAT_O;
        rdata_nxt = cpu_rdata;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    idx_nxt = req_idx;
                    if (req_valid) begin
                        state_nxt = ACCESS;
                        stb_nxt   = req_onehot;
                        we_nxt    = cpu_we;
                        dat_o_nxt = cpu_wdata;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (sel_ack) begin
                    if (!WE) rdata_nxt = sel_dat;
                    stb_nxt   = '0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (timer == T_LAST) begin
                    stb_nxt   = '0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                stb_nxt   = '0;
                we_nxt    = 1'b0;
            end
        endcase
        ack_nxt  = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= '0;
            STB       <= '0;
            WE        <= 1'b0;
            DAT_O     <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            timer     <= timer_nxt;
            STB       <= stb_nxt;
            WE        <= we_nxt;
            DAT_O     <= dat_o_nxt;
            cpu_rdata <= rdata_nxt;
            cpu_ack   <= ack_nxt;
            cpu_err   <= err_nxt;
            cpu_busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bus_master.sv
// Bench for wb_bus_master: transaction-level expectations derived from the latency
// rules (STB for min(ack cycle, TIMEOUT) cycles, then one cpu_ack cycle), checked every cycle.
module tb_wb_bus_master;

    localparam int NS = 4;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req, cpu_we;
    logic [31:0]     cpu_addr, cpu_wdata;
    logic [31:0]     cpu_rdata;
    logic            cpu_ack, cpu_err, cpu_busy;
    logic [NS-1:0]   STB;
    logic            WE;
    logic [31:0]     DAT_O;
    logic [32*NS-1:0] DAT_I;
    logic [NS-1:0]   ACK;

    wb_bus_master #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .STB(STB), .WE(WE), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK(ACK)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int ack_pulses = 0;
    logic chk_en   = 1'b0;

    logic [NS-1:0] exp_stb;
    logic          exp_we, exp_ack, exp_err, exp_busy;
    logic [31:0]   exp_dat, exp_rdata;
    logic [31:0]   m_dat   = 32'h0;
    logic [31:0]   m_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("STB",       32'(STB),      32'(exp_stb));
            check("WE",        32'(WE),       32'(exp_we));
            check("DAT_O",     DAT_O,         exp_dat);
            check("cpu_rdata", cpu_rdata,     exp_rdata);
            check("cpu_ack",   32'(cpu_ack),  32'(exp_ack));
            check("cpu_err",   32'(cpu_err),  32'(exp_err));
            check("cpu_busy",  32'(cpu_busy), 32'(exp_busy));
        end
    end

    always @(negedge clk) if (cpu_ack === 1'b1) ack_pulses++;

    task automatic set_idle_exp();
        exp_stb   = '0;
        exp_we    = 1'b0;
        exp_ack   = 1'b0;
        exp_err   = 1'b0;
        exp_busy  = 1'b0;
        exp_dat   = m_dat;
        exp_rdata = m_rdata;
    endtask

    // Slave side: random data everywhere, selected slave answers when ack_now; stray ACKs on others.
    task automatic drive_slaves(input int slv, input logic ack_now, input logic [31:0] rdv, input logic stray);
        ACK = '0;
        for (int k = 0; k < NS; k++) begin
            DAT_I[32*k +: 32] = $urandom;
            if (stray && k != slv) ACK[k] = 1'($urandom_range(0, 1));
        end
        if (ack_now && slv >= 0 && slv < NS) begin
            ACK[slv]            = 1'b1;
            DAT_I[32*slv +: 32] = rdv;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        cpu_req = 1'b0;
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        set_idle_exp();
    endtask

    // ack_at: STB cycle (1-based) on which the slave ACKs; 0 or > TO means it never does.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdv,
                           input logic stray, input logic extra);
        int slv    = int'(addr[31:28]);
        bit valid  = slv < NS;
        bit acked  = valid && ack_at >= 1 && ack_at <= TO;
        int n_stb  = valid ? (acked ? ack_at : TO) : 0;
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        drive_slaves(-1, 1'b0, 32'h0, stray);
        set_idle_exp();
        if (valid) m_dat = wdata;
        for (int c = 1; c <= n_stb + 1; c++) begin
            @(posedge clk); #1;
            cpu_req = extra ? 1'($urandom_range(0, 1)) : 1'b0;
            if (extra) begin
                cpu_addr = $urandom;
                cpu_we   = 1'($urandom);
            end
            exp_dat  = m_dat;
            exp_busy = 1'b1;
            if (c <= n_stb) begin
                drive_slaves(slv, acked && c == ack_at, rdv, stray);
                exp_stb      = '0;
                exp_stb[slv] = 1'b1;
                exp_we       = we;
                exp_ack      = 1'b0;
                exp_err      = 1'b0;
            end else begin
                drive_slaves(valid ? slv : -1, 1'b0, 32'h0, stray);
                if (acked && !we) m_rdata = rdv;
                exp_stb = '0;
                exp_we  = 1'b0;
                exp_ack = 1'b1;
                exp_err = !acked;
            end
            exp_rdata = m_rdata;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        DAT_I     = '0;
        ACK       = '0;
        #12;
        check("rst_STB",   32'(STB),      32'h0);
        check("rst_WE",    32'(WE),       32'h0);
        check("rst_DAT_O", DAT_O,         32'h0);
        check("rst_rdata", cpu_rdata,     32'h0);
        check("rst_ack",   32'(cpu_ack),  32'h0);
        check("rst_err",   32'(cpu_err),  32'h0);
        check("rst_busy",  32'(cpu_busy), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;

        run_txn(1'b1, 32'h3000_0000, 32'h0000_1234, 2, 32'h0, 1'b0, 1'b0);
        check("t1_ack_lit",  32'(cpu_ack), 32'h1);
        check("t1_dato_lit", DAT_O,        32'h0000_1234);

        run_txn(1'b0, 32'h1000_0000, 32'h0, 3, 32'hCAFE_0001, 1'b0, 1'b0);
        check("t2_rdata_lit", cpu_rdata,   32'hCAFE_0001);
        check("t2_stb_lit",   32'(STB),    32'h0);

        run_txn(1'b1, 32'h7000_0000, 32'h0000_DEAD, 0, 32'h0, 1'b0, 1'b0);
        check("t3_err_lit", 32'(cpu_err), 32'h1);

        run_txn(1'b0, 32'h2000_0010, 32'h0, 0, 32'h5555_5555, 1'b0, 1'b0);
        check("t4_err_lit",   32'(cpu_err), 32'h1);
        check("t4_rdata_lit", cpu_rdata,    32'hCAFE_0001);

        run_txn(1'b0, 32'h2000_0000, 32'h0, 15, 32'h0BAD_F00D, 1'b0, 1'b0);
        check("t4b_err_lit",   32'(cpu_err), 32'h0);
        check("t4b_rdata_lit", cpu_rdata,    32'h0BAD_F00D);

        run_txn(1'b0, 32'h2000_0004, 32'h0, 4, 32'h1357_9BDF, 1'b1, 1'b1);
        idle_cycle();
        idle_cycle();
        check("ack_count_lit", 32'(ack_pulses), 32'd6);

        // Reset in the middle of an access to slave 2.
        chk_en = 1'b0;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h2000_0000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("t6_stb_before", 32'(STB), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check("t6_stb_async",  32'(STB),      32'h0);
        check("t6_busy_async", 32'(cpu_busy), 32'h0);
        @(posedge clk); #1;
        reset   = 1'b0;
        m_dat   = 32'h0;
        m_rdata = 32'h0;
        idle_cycle();
        chk_en = 1'b1;
        idle_cycle();
        idle_cycle();
        check("t6_no_ack_lit", 32'(ack_pulses), 32'd6);
        run_txn(1'b1, 32'h0000_0000, 32'h0000_A5A5, 1, 32'h0, 1'b0, 1'b0);
        check("t6_next_ack_lit", 32'(cpu_ack), 32'h1);

        repeat (60) begin
            run_txn(1'($urandom), {4'($urandom_range(0, 6)), 28'($urandom)}, $urandom,
                    $urandom_range(0, 17), $urandom, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
